// File: rtl/grid_scanner.sv
// grid_scanner
//   Generates 2-D board coordinates over a valid/ready handshake. It walks either
//   the whole cols x rows board in raster order (x fastest) or the 3x3
//   neighbourhood of (cx,cy), clipped to the board edges. The centre cell is
//   optionally left out of the neighbourhood walk.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   start             begin a scan (taken only when idle)
//   mode              0 = full-board raster, 1 = neighbourhood of (cx,cy)
//   cols, rows        board size in cells
//   cx, cy            neighbourhood centre
//   abort             abandon the scan in progress (no done pulse)
//   coord_ready       consumer accepts the offered coordinate
//   x_out, y_out      offered coordinate
//   coord_valid       x_out/y_out are valid
//   coord_last        offered coordinate is the final one of the scan
//   busy              scan in progress
//   done              one-cycle pulse once the final coordinate is accepted
module grid_scanner #(
  parameter int CW          = 5,
  parameter bit SKIP_CENTRE = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [CW-1:0] cols,
  input  logic [CW-1:0] rows,
  input  logic [CW-1:0] cx,
  input  logic [CW-1:0] cy,
  input  logic          abort,
  input  logic          coord_ready,
  output logic [CW-1:0] x_out,
  output logic [CW-1:0] y_out,
  output logic          coord_valid,
  output logic          coord_last,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] ZERO_X = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_X  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW:0]   ONE_Y  = {{CW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Next position after (x,y), returned as {y,x}. y carries an extra bit so that
  // stepping off the last row is visible as y > ymax. When skipping is enabled a
  // landing on the centre steps once more in the same call.
  function automatic logic [2*CW:0] f_step(
    input logic [CW-1:0] x,
    input logic [CW:0]   y,
    input logic [CW-1:0] xmin,
    input logic [CW-1:0] xmax,
    input logic [CW-1:0] c_x,
    input logic [CW-1:0] c_y,
    input logic          skip
  );
    logic [CW-1:0] nx;
    logic [CW:0]   ny;
    if (x == xmax) begin
      nx = xmin;
      ny = y + ONE_Y;
    end else begin
      nx = x + ONE_X;
      ny = y;
    end
    if (skip && (nx == c_x) && (ny == {1'b0, c_y})) begin
      if (nx == xmax) begin
        nx = xmin;
        ny = ny + ONE_Y;
      end else begin
        nx = nx + ONE_X;
      end
    end
    return {ny, nx};
  endfunction

  // True when the {y,x} position has left the scan area. Comparing the whole word
  // against {ymax, all-ones} is the same as comparing y against ymax.
  function automatic logic f_past_end(
    input logic [2*CW:0] pos,
    input logic [CW-1:0] ymax
  );
    return pos > {1'b0, ymax, {CW{1'b1}}};
  endfunction

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic          r_last, w_last_nxt, r_busy, r_done, w_take;
  logic [CW-1:0] r_xmin, r_xmax, r_ymax, r_cx, r_cy;
  logic          r_skip;

  logic [CW:0]   w_cxp1, w_cyp1;
  logic [CW-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
  logic          w_skip, w_empty, w_first_last, w_step_last;
  logic [2*CW:0] w_first, w_step;

  // Scan bounds, emptiness and first coordinate derived from the live inputs.
  always_comb begin
    w_cxp1 = {1'b0, cx} + ONE_Y;
    w_cyp1 = {1'b0, cy} + ONE_Y;
    w_skip = mode & SKIP_CENTRE;
    if (mode) begin
      w_xmin = (cx == ZERO_X) ? ZERO_X : cx - ONE_X;
      w_ymin = (cy == ZERO_X) ? ZERO_X : cy - ONE_X;
      w_xmax = (w_cxp1 < {1'b0, cols}) ? w_cxp1[CW-1:0] : cols - ONE_X;
      w_ymax = (w_cyp1 < {1'b0, rows}) ? w_cyp1[CW-1:0] : rows - ONE_X;
    end else begin
      w_xmin = ZERO_X;
      w_ymin = ZERO_X;
      w_xmax = cols - ONE_X;
      w_ymax = rows - ONE_X;
    end
    // A skipped-centre walk of a 1x1 board has nothing left to offer.
    w_empty = (cols == ZERO_X) || (rows == ZERO_X) ||
              (mode && ((cx >= cols) || (cy >= rows))) ||
              (w_skip && (cols == ONE_X) && (rows == ONE_X));
    if (w_skip && (w_xmin == cx) && (w_ymin == cy)) begin
      w_first = f_step(w_xmin, {1'b0, w_ymin}, w_xmin, w_xmax, cx, cy, w_skip);
    end else begin
      w_first = {1'b0, w_ymin, w_xmin};
    end
    w_first_last = f_past_end(f_step(w_first[CW-1:0], w_first[2*CW:CW],
                                     w_xmin, w_xmax, cx, cy, w_skip), w_ymax);
  end

  // Successor of the offered coordinate and whether that successor is final.
  always_comb begin
    w_step      = f_step(r_x, {1'b0, r_y}, r_xmin, r_xmax, r_cx, r_cy, r_skip);
    w_step_last = f_past_end(f_step(w_step[CW-1:0], w_step[2*CW:CW],
                                    r_xmin, r_xmax, r_cx, r_cy, r_skip), r_ymax);
  end

  // Next-state and next-coordinate logic.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_last_nxt  = r_last;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (start) begin
          w_take = 1'b1;
          if (w_empty) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SCAN;
            w_x_nxt     = w_first[CW-1:0];
            w_y_nxt     = w_first[2*CW-1:CW];
            w_last_nxt  = w_first_last;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SCAN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (coord_ready) begin
          if (r_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SCAN;
            w_x_nxt     = w_step[CW-1:0];
            w_y_nxt     = w_step[2*CW-1:CW];
            w_last_nxt  = w_step_last;
          end
        end else begin
          w_state_nxt = S_SCAN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs (zeroed outside a scan) and bounds latched at start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x    <= ZERO_X;
      r_y    <= ZERO_X;
      r_last <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_xmin <= ZERO_X;
      r_xmax <= ZERO_X;
      r_ymax <= ZERO_X;
      r_cx   <= ZERO_X;
      r_cy   <= ZERO_X;
      r_skip <= 1'b0;
    end else begin
      r_x    <= (w_state_nxt == S_SCAN) ? w_x_nxt : ZERO_X;
      r_y    <= (w_state_nxt == S_SCAN) ? w_y_nxt : ZERO_X;
      r_last <= (w_state_nxt == S_SCAN) ? w_last_nxt : 1'b0;
      r_busy <= (w_state_nxt == S_SCAN);
      r_done <= (w_state_nxt == S_DONE);
      if (w_take) begin
        r_xmin <= w_xmin;
        r_xmax <= w_xmax;
        r_ymax <= w_ymax;
        r_cx   <= cx;
        r_cy   <= cy;
        r_skip <= w_skip;
      end
    end
  end

  assign x_out       = r_x;
  assign y_out       = r_y;
  assign coord_valid = r_busy;
  assign coord_last  = r_last;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_grid_scanner.sv
// Bench for grid_scanner: two instances (centre skipped / centre included) share
// all inputs. A list-based model builds each scan's coordinate list from the
// board rules and is compared with both instances every cycle; directed tests
// pin the model with hand-computed coordinate sequences and latencies.
module tb_grid_scanner;
  localparam int CW = 5;

  logic clk, rst_n, start, mode, abort, ready;
  logic [CW-1:0] cols, rows, cx, cy;
  logic [CW-1:0] x0, y0, x1, y1;
  logic v0, l0, b0, d0, v1, l1, b1, d1;

  grid_scanner #(.CW(CW), .SKIP_CENTRE(1'b1)) dut_skip (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .cols(cols), .rows(rows),
    .cx(cx), .cy(cy), .abort(abort), .coord_ready(ready), .x_out(x0), .y_out(y0),
    .coord_valid(v0), .coord_last(l0), .busy(b0), .done(d0));

  grid_scanner #(.CW(CW), .SKIP_CENTRE(1'b0)) dut_full (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .cols(cols), .rows(rows),
    .cx(cx), .cy(cy), .abort(abort), .coord_ready(ready), .x_out(x1), .y_out(y1),
    .coord_valid(v1), .coord_last(l1), .busy(b1), .done(d1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // model: per instance, the coordinate list of the current scan and a cursor
  logic [2*CW-1:0] mlist [0:1][0:1023];
  int mlen [0:1];
  int mpos [0:1];
  bit m_act [0:1];
  bit m_done [0:1];

  // handshake log and done counter taken from the DUTs
  int lx [0:1][0:63];
  int ly [0:1][0:63];
  bit ll [0:1][0:63];
  int ln [0:1];
  int dn [0:1];
  int lat [0:1];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic build(input int k);
    int c, r, px, py, xl, xh, yl, yh;
    bit skip;
    c = int'(cols); r = int'(rows); px = int'(cx); py = int'(cy);
    skip = (k == 0) && (mode == 1'b1);
    mlen[k] = 0;
    mpos[k] = 0;
    if (c == 0 || r == 0) return;
    if (mode == 1'b0) begin
      xl = 0; xh = c - 1; yl = 0; yh = r - 1;
    end else begin
      if (px >= c || py >= r) return;
      xl = (px > 0) ? px - 1 : 0;
      yl = (py > 0) ? py - 1 : 0;
      xh = (px + 1 < c) ? px + 1 : c - 1;
      yh = (py + 1 < r) ? py + 1 : r - 1;
    end
    for (int y = yl; y <= yh; y++) begin
      for (int x = xl; x <= xh; x++) begin
        if (!(skip && x == px && y == py)) begin
          mlist[k][mlen[k]] = {CW'(y), CW'(x)};
          mlen[k]++;
        end
      end
    end
  endtask

  // model update on every clock edge
  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_act[k] = 1'b0;
        m_done[k] = 1'b0;
      end else begin
        bit was_done;
        was_done = m_done[k];
        m_done[k] = 1'b0;
        if (m_act[k]) begin
          if (abort) m_act[k] = 1'b0;
          else if (ready) begin
            mpos[k]++;
            if (mpos[k] == mlen[k]) begin
              m_act[k] = 1'b0;
              m_done[k] = 1'b1;
            end
          end
        end else if (!was_done && start && !abort) begin
          build(k);
          if (mlen[k] == 0) m_done[k] = 1'b1;
          else m_act[k] = 1'b1;
        end
      end
    end
  end

  // handshake logger
  initial forever begin
    @(posedge clk);
    if (rst_n && ready && !abort) begin
      if (v0 && ln[0] < 64) begin
        lx[0][ln[0]] = int'(x0); ly[0][ln[0]] = int'(y0); ll[0][ln[0]] = l0; ln[0]++;
      end
      if (v1 && ln[1] < 64) begin
        lx[1][ln[1]] = int'(x1); ly[1][ln[1]] = int'(y1); ll[1][ln[1]] = l1; ln[1]++;
      end
    end
    if (rst_n && d0) dn[0]++;
    if (rst_n && d1) dn[1]++;
  end

  task automatic cmp_one(input int k, input logic [CW-1:0] ax, input logic [CW-1:0] ay,
                         input logic av, input logic al, input logic ab, input logic ad);
    logic [2*CW-1:0] c;
    c = m_act[k] ? mlist[k][mpos[k]] : {(2*CW){1'b0}};
    chk($sformatf("x_out dut%0d", k), int'(ax), int'(c[CW-1:0]));
    chk($sformatf("y_out dut%0d", k), int'(ay), int'(c[2*CW-1:CW]));
    chk($sformatf("coord_valid dut%0d", k), int'(av), int'(m_act[k]));
    chk($sformatf("busy dut%0d", k), int'(ab), int'(m_act[k]));
    chk($sformatf("coord_last dut%0d", k), int'(al),
        int'(m_act[k] && (mpos[k] == mlen[k] - 1)));
    chk($sformatf("done dut%0d", k), int'(ad), int'(m_done[k]));
  endtask

  // per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      cmp_one(0, x0, y0, v0, l0, b0, d0);
      cmp_one(1, x1, y1, v1, l1, b1, d1);
    end
  end

  // runs until both instances have pulsed done; lat = inclusive start..done cycles
  task automatic wait_both(input int rpat, input int poke);
    int n;
    bit s0, s1;
    n = 0; s0 = 1'b0; s1 = 1'b0;
    lat[0] = 0; lat[1] = 0; ln[0] = 0; ln[1] = 0;
    while (!(s0 && s1) && n < 2000) begin
      @(negedge clk);
      n++;
      start = (n == poke);
      if (n == poke) cols = CW'(7);
      ready = (rpat == 0) || ((n % 3) == 0);
      if (d0 && !s0) begin s0 = 1'b1; lat[0] = n + 1; end
      if (d1 && !s1) begin s1 = 1'b1; lat[1] = n + 1; end
    end
    chk("scan completes", int'(s0 && s1), 1);
    @(negedge clk);
    start = 1'b0;
    ready = 1'b1;
  endtask

  task automatic run_scan(input bit m, input int c, input int r, input int px,
                          input int py, input int rpat, input int poke);
    mode = m; cols = CW'(c); rows = CW'(r); cx = CW'(px); cy = CW'(py);
    ready = 1'b1;
    start = 1'b1;
    wait_both(rpat, poke);
  endtask

  task automatic chk_log(input string name, input int k, input int i, input int x, input int y);
    chk($sformatf("%s[%0d].x", name, i), lx[k][i], x);
    chk($sformatf("%s[%0d].y", name, i), ly[k][i], y);
  endtask

  initial begin
    int ex [0:5];
    int ey [0:5];
    int dnb0, dnb1;
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int ex [0:5];
    int ey [0:5];
    int dnb0, dnb1;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0; ready = 1'b1;
    cols = CW'(0); rows = CW'(0); cx = CW'(0); cy = CW'(0);
    ln[0] = 0; ln[1] = 0; dn[0] = 0; dn[1] = 0;
    repeat (2) @(negedge clk);
    chk("reset x_out", int'(x0), 0);
    chk("reset y_out", int'(y0), 0);
    chk("reset coord_valid", int'(v0), 0);
    chk("reset busy", int'(b0), 0);
    chk("reset done", int'(d1), 0);
    chk_en = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    // 1: raster 3x2, ready high, a mid-scan start and cols change are ignored
    run_scan(1'b0, 3, 2, 0, 0, 0, 3);
    ex = '{0, 1, 2, 0, 1, 2};
    ey = '{0, 0, 0, 1, 1, 1};
    chk("raster3x2 count", ln[0], 6);
    for (int i = 0; i < 6; i++) begin
      chk_log("raster3x2", 0, i, ex[i], ey[i]);
      chk($sformatf("raster3x2 last[%0d]", i), int'(ll[0][i]), (i == 5) ? 1 : 0);
    end
    chk("raster3x2 latency", lat[0], 8);
    chk("raster3x2 latency full", lat[1], 8);

    // 2: raster 2x2 with stalls
    run_scan(1'b0, 2, 2, 0, 0, 1, -1);
    chk("stall count", ln[0], 4);
    chk_log("stall", 0, 0, 0, 0);
    chk_log("stall", 0, 1, 1, 0);
    chk_log("stall", 0, 2, 0, 1);
    chk_log("stall", 0, 3, 1, 1);

    // 3: corner neighbourhoods on 8x8
    run_scan(1'b1, 8, 8, 0, 0, 0, -1);
    chk("nb00 count", ln[0], 3);
    chk_log("nb00", 0, 0, 1, 0);
    chk_log("nb00", 0, 1, 0, 1);
    chk_log("nb00", 0, 2, 1, 1);
    chk("nb00 full count", ln[1], 4);
    run_scan(1'b1, 8, 8, 7, 7, 0, -1);
    chk("nb77 count", ln[0], 3);
    chk_log("nb77", 0, 0, 6, 6);
    chk_log("nb77", 0, 1, 7, 6);
    chk_log("nb77", 0, 2, 6, 7);
    chk("nb77 last", int'(ll[0][2]), 1);
    chk("nb77 full count", ln[1], 4);

    // 4: interior neighbourhood
    run_scan(1'b1, 8, 8, 3, 3, 0, -1);
    chk("nb33 full count", ln[1], 9);
    chk_log("nb33 full", 1, 0, 2, 2);
    chk_log("nb33 full", 1, 4, 3, 3);
    chk_log("nb33 full", 1, 8, 4, 4);
    chk("nb33 skip count", ln[0], 8);

    // 5: empty scans; a start during done is ignored
    run_scan(1'b0, 0, 4, 0, 0, 0, 1);
    chk("empty cols latency", lat[0], 2);
    chk("empty cols count", ln[0], 0);
    run_scan(1'b1, 8, 8, 9, 2, 0, -1);
    chk("empty cx latency", lat[1], 2);
    chk("empty cx count", ln[1], 0);
    run_scan(1'b1, 1, 1, 0, 0, 0, -1);
    chk("1x1 skip latency", lat[0], 2);
    chk("1x1 skip count", ln[0], 0);
    chk("1x1 full latency", lat[1], 3);
    chk("1x1 full count", ln[1], 1);

    // width edge: centre on the largest board's last cell
    run_scan(1'b1, 31, 31, 30, 30, 0, -1);
    chk("nb30 count", ln[0], 3);
    chk_log("nb30", 0, 0, 29, 29);
    chk_log("nb30", 0, 2, 29, 30);
    chk("nb30 full count", ln[1], 4);

    // abort in idle beats start
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("idle abort valid", int'(v0), 0);
    chk("idle abort done", int'(d0), 0);
    @(negedge clk);

    // 6: abort after two handshakes, restart, then reset mid-scan
    dnb0 = dn[0]; dnb1 = dn[1];
    mode = 1'b0; cols = CW'(4); rows = CW'(4); ready = 1'b1;
    ln[0] = 0; ln[1] = 0;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort valid", int'(v0), 0);
    chk("abort busy", int'(b0), 0);
    chk("abort x_out", int'(x0), 0);
    chk("abort handshakes", ln[0], 2);
    chk_log("abort", 0, 1, 1, 0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("restart valid", int'(v0), 1);
    chk("restart x_out", int'(x0), 0);
    chk("restart y_out", int'(y0), 0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("midreset valid", int'(v0), 0);
    chk("midreset x_out", int'(x0), 0);
    chk("midreset last", int'(l1), 0);
    chk("midreset done", int'(d0), 0);
    chk("no done after abort/reset", dn[0], dnb0);
    chk("no done after abort/reset full", dn[1], dnb1);
    rst_n = 1'b1;
    start = 1'b1;
    wait_both(0, -1);
    chk("post-reset count", ln[0], 16);
    chk_log("post-reset", 0, 0, 0, 0);
    chk("post-reset done pulses", dn[0], dnb0 + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
